// File: rtl/daq_sram_writer.sv
// daq_sram_writer: Wishbone write master that streams one DAQ channel into a circular SRAM buffer.
// Optional ack watchdog of TIMEOUT_CYCLES is built only when DAQ_SRAM_WRITER_TIMEOUT_EN is defined.
module daq_sram_writer #(
  parameter int dw             = 32,
  parameter int aw             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          enable,
  input  logic          start_sram,
  input  logic [dw-1:0] data_in,
  input  logic [aw-1:0] base_address,
  input  logic [15:0]   buffer_words,
  output logic          data_done,
  output logic [aw-1:0] m_wb_adr_o,
  output logic [dw-1:0] m_wb_dat_o,
  output logic [3:0]    m_wb_sel_o,
  output logic          m_wb_we_o,
  output logic          m_wb_cyc_o,
  output logic          m_wb_stb_o,
  input  logic          m_wb_ack_i,
  input  logic          m_wb_err_i,
  output logic [15:0]   word_count,
  output logic          buffer_wrap,
  output logic          error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q;
  logic          enable_q;
  logic [15:0]   index_q;
  logic [15:0]   index_d;
  logic [15:0]   count_q;
  logic [15:0]   count_d;
  logic          wrap_d;
  logic [aw-1:0] adr_q;
  logic [aw-1:0] adr_d;
  logic [dw-1:0] dat_q;
  logic [3:0]    sel_q;
  logic          we_q;
  logic          cyc_q;
  logic          stb_q;
  logic          done_q;
  logic          wrap_q;
  logic          error_q;

  logic          enable_rise_s;
  logic [15:0]   last_idx_s;
  logic [15:0]   start_idx_s;
  logic          timeout_s;
  logic          bus_fail_s;
  logic [1:0]    unused_adr_s;

  assign unused_adr_s = base_address[1:0];

  // Next index/count, wrap decision and the word address for a new transaction.
  always_comb begin
    enable_rise_s = enable & ~enable_q;
    // A zero length buffer behaves as a single-word buffer.
    if (buffer_words == 16'd0) begin
      last_idx_s = 16'd0;
    end else begin
      last_idx_s = buffer_words - 16'd1;
    end
    // >= so that shrinking buffer_words below the live index still wraps cleanly.
    if (index_q >= last_idx_s) begin
      index_d = 16'd0;
      wrap_d  = 1'b1;
    end else begin
      index_d = index_q + 16'd1;
      wrap_d  = 1'b0;
    end
    if (count_q == 16'hFFFF) begin
      count_d = count_q;
    end else begin
      count_d = count_q + 16'd1;
    end
    if (enable_rise_s) begin
      start_idx_s = 16'd0;
    end else begin
      start_idx_s = index_q;
    end
    adr_d = {base_address[aw-1:2], 2'b00} + aw'({start_idx_s, 2'b00});
  end

`ifdef DAQ_SRAM_WRITER_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDW-1:0] wd_q;

  assign timeout_s = (state_q == WRITE) && (wd_q == WDW'(TIMEOUT_CYCLES - 1));

  // Ack watchdog: counts cycles spent in WRITE, restarted outside it.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      wd_q <= '0;
    end else if (state_q != WRITE) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + WDW'(1);
    end
  end
`else
  logic [31:0] unused_timeout_s;

  assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
  assign timeout_s        = 1'b0;
`endif

  // An error (or watchdog expiry) takes priority over a simultaneous ack.
  assign bus_fail_s = m_wb_err_i | timeout_s;

  // Transaction state machine with all bus and status outputs registered.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state_q  <= IDLE;
      enable_q <= 1'b0;
      index_q  <= 16'd0;
      count_q  <= 16'd0;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= 4'h0;
      we_q     <= 1'b0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      enable_q <= enable;
      if (enable_rise_s) begin
        index_q <= 16'd0;
        count_q <= 16'd0;
        error_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          wrap_q <= 1'b0;
          if (enable && start_sram) begin
            adr_q   <= adr_d;
            dat_q   <= data_in;
            sel_q   <= 4'hF;
            we_q    <= 1'b1;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (bus_fail_s || m_wb_ack_i) begin
            sel_q   <= 4'h0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
            if (bus_fail_s) begin
              error_q <= 1'b1;
            end else begin
              index_q <= index_d;
              count_q <= count_d;
              wrap_q  <= wrap_d;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          wrap_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          sel_q   <= 4'h0;
          we_q    <= 1'b0;
          cyc_q   <= 1'b0;
          stb_q   <= 1'b0;
          done_q  <= 1'b0;
          wrap_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_done   = done_q;
  assign m_wb_adr_o  = adr_q;
  assign m_wb_dat_o  = dat_q;
  assign m_wb_sel_o  = sel_q;
  assign m_wb_we_o   = we_q;
  assign m_wb_cyc_o  = cyc_q;
  assign m_wb_stb_o  = stb_q;
  assign word_count  = count_q;
  assign buffer_wrap = wrap_q;
  assign error       = error_q;

endmodule

// File: tb/tb_daq_sram_writer.sv
// Self-checking bench for daq_sram_writer: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the capture buffer.
module tb_daq_sram_writer;

  logic        wb_clk;
  logic        wb_rst;
  logic        enable;
  logic        start_sram;
  logic [31:0] data_in;
  logic [31:0] base_address;
  logic [15:0] buffer_words;
  logic        data_done;
  logic [31:0] m_wb_adr_o;
  logic [31:0] m_wb_dat_o;
  logic [3:0]  m_wb_sel_o;
  logic        m_wb_we_o;
  logic        m_wb_cyc_o;
  logic        m_wb_stb_o;
  logic        m_wb_ack_i;
  logic        m_wb_err_i;
  logic [15:0] word_count;
  logic        buffer_wrap;
  logic        error;

  daq_sram_writer #(.dw(32), .aw(32), .TIMEOUT_CYCLES(8)) dut (
    .wb_clk       (wb_clk),
    .wb_rst       (wb_rst),
    .enable       (enable),
    .start_sram   (start_sram),
    .data_in      (data_in),
    .base_address (base_address),
    .buffer_words (buffer_words),
    .data_done    (data_done),
    .m_wb_adr_o   (m_wb_adr_o),
    .m_wb_dat_o   (m_wb_dat_o),
    .m_wb_sel_o   (m_wb_sel_o),
    .m_wb_we_o    (m_wb_we_o),
    .m_wb_cyc_o   (m_wb_cyc_o),
    .m_wb_stb_o   (m_wb_stb_o),
    .m_wb_ack_i   (m_wb_ack_i),
    .m_wb_err_i   (m_wb_err_i),
    .word_count   (word_count),
    .buffer_wrap  (buffer_wrap),
    .error        (error)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Model of the buffer state and of what the outputs must show this cycle.
  logic [15:0] m_idx   = 16'd0;
  logic [15:0] m_count = 16'd0;
  logic        m_err   = 1'b0;
  logic        e_cyc   = 1'b0;
  logic        e_done  = 1'b0;
  logic        e_wrap  = 1'b0;
  logic [31:0] e_adr   = 32'd0;
  logic [31:0] e_dat   = 32'd0;
  bit          chk_on  = 1'b0;

  logic [31:0] cap_adr;
  logic        cap_done;
  logic        cap_wrap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, half a period after the active edge.
  initial begin
    forever begin
      @(negedge wb_clk);
      #1;
      if (chk_on) begin
        check("cyc", {31'd0, m_wb_cyc_o}, {31'd0, e_cyc});
        check("stb", {31'd0, m_wb_stb_o}, {31'd0, e_cyc});
        if (e_cyc) begin
          check("adr", m_wb_adr_o, e_adr);
          check("dat", m_wb_dat_o, e_dat);
          check("sel", {28'd0, m_wb_sel_o}, 32'h0000_000F);
          check("we", {31'd0, m_wb_we_o}, 32'd1);
        end
        check("data_done", {31'd0, data_done}, {31'd0, e_done});
        check("buffer_wrap", {31'd0, buffer_wrap}, {31'd0, e_wrap});
        check("word_count", {16'd0, word_count}, {16'd0, m_count});
        check("error", {31'd0, error}, {31'd0, m_err});
      end
    end
  end

  // One channel request. kind: 0 ack, 1 err, 2 ack+err, 3 no response (watchdog).
  task automatic write_word(input logic [31:0] data, input int ws, input int kind, input bit drop_en);
    logic [31:0] a;
    logic [15:0] last;
    bit          fail;
    a = (base_address & 32'hFFFF_FFFC) + {14'd0, m_idx, 2'b00};
    start_sram = 1'b1;
    data_in    = data;
    @(negedge wb_clk);
    e_cyc = 1'b1;
    e_adr = a;
    e_dat = data;
    cap_adr = m_wb_adr_o;
    if (drop_en) enable = 1'b0;
    repeat (ws) @(negedge wb_clk);
    fail = (kind != 0);
    if (kind == 0 || kind == 2) m_wb_ack_i = 1'b1;
    if (kind == 1 || kind == 2) m_wb_err_i = 1'b1;
    @(negedge wb_clk);
    m_wb_ack_i = 1'b0;
    m_wb_err_i = 1'b0;
    start_sram = 1'b0;
    e_cyc  = 1'b0;
    e_done = 1'b1;
    if (fail) begin
      m_err = 1'b1;
    end else begin
      last    = (buffer_words == 16'd0) ? 16'd0 : buffer_words - 16'd1;
      e_wrap  = (m_idx >= last);
      m_idx   = e_wrap ? 16'd0 : m_idx + 16'd1;
      m_count = (m_count == 16'hFFFF) ? m_count : m_count + 16'd1;
    end
    cap_done = data_done;
    cap_wrap = buffer_wrap;
    @(negedge wb_clk);
    e_done = 1'b0;
    e_wrap = 1'b0;
  endtask

  task automatic re_enable();
    enable = 1'b0;
    @(negedge wb_clk);
    enable = 1'b1;
    @(negedge wb_clk);
    m_idx   = 16'd0;
    m_count = 16'd0;
    m_err   = 1'b0;
    @(negedge wb_clk);
  endtask

  logic [31:0] wrap_adr_exp [5];
  logic [31:0] wrap_adr_got [5];
  logic [4:0]  wrap_seen;

  initial begin
    wb_rst = 1'b0; enable = 1'b0; start_sram = 1'b0; data_in = 32'd0;
    base_address = 32'd0; buffer_words = 16'd0; m_wb_ack_i = 1'b0; m_wb_err_i = 1'b0;
    wrap_adr_exp[0] = 32'h1000; wrap_adr_exp[1] = 32'h1004; wrap_adr_exp[2] = 32'h1008;
    wrap_adr_exp[3] = 32'h100C; wrap_adr_exp[4] = 32'h1000;

    repeat (2) @(negedge wb_clk);
    check("rst_cyc", {31'd0, m_wb_cyc_o}, 32'd0);
    check("rst_done", {31'd0, data_done}, 32'd0);
    check("rst_adr", m_wb_adr_o, 32'd0);
    check("rst_dat", m_wb_dat_o, 32'd0);
    check("rst_sel", {28'd0, m_wb_sel_o}, 32'd0);
    check("rst_count", {16'd0, word_count}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    wb_rst = 1'b1;
    chk_on = 1'b1;
    base_address = 32'h1000;
    buffer_words = 16'd4;
    @(negedge wb_clk);
    enable = 1'b1;
    repeat (2) @(negedge wb_clk);

    // Basic write with two wait states.
    write_word(32'hDEADBEEF, 2, 0, 1'b0);
    check("basic_adr", cap_adr, 32'h1000);
    check("basic_done", {31'd0, cap_done}, 32'd1);
    check("basic_count", {16'd0, word_count}, 32'd1);

    // Five back-to-back words into a four-word buffer.
    re_enable();
    for (int k = 0; k < 5; k++) begin
      write_word($urandom, 0, 0, 1'b0);
      wrap_adr_got[k] = cap_adr;
      wrap_seen[k]    = cap_wrap;
    end
    for (int k = 0; k < 5; k++) check("wrap_adr", wrap_adr_got[k], wrap_adr_exp[k]);
    check("wrap_pulse", {27'd0, wrap_seen}, 32'h0000_0008);
    check("wrap_count", {16'd0, word_count}, 32'd5);

    // Bus error on the second word.
    re_enable();
    write_word(32'h1111_1111, 1, 0, 1'b0);
    write_word(32'h2222_2222, 1, 1, 1'b0);
    check("err_flag", {31'd0, error}, 32'd1);
    check("err_done", {31'd0, cap_done}, 32'd1);
    write_word(32'h3333_3333, 0, 0, 1'b0);
    check("err_retry_adr", cap_adr, 32'h1004);
    check("err_count", {16'd0, word_count}, 32'd2);

    // Enable drops mid-write, a start while disabled is ignored, then re-enable.
    write_word(32'h4444_4444, 3, 0, 1'b1);
    check("drop_done", {31'd0, cap_done}, 32'd1);
    start_sram = 1'b1;
    repeat (3) @(negedge wb_clk);
    start_sram = 1'b0;
    re_enable();
    check("reen_count", {16'd0, word_count}, 32'd0);
    check("reen_error", {31'd0, error}, 32'd0);
    write_word(32'h5555_5555, 0, 0, 1'b0);
    check("reen_adr", cap_adr, 32'h1000);

    // Randomized traffic: geometry changes, wait states, errors and idle gaps.
    for (int t = 0; t < 60; t++) begin
      int r;
      if ($urandom_range(0, 4) == 0) buffer_words = 16'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) base_address = $urandom & 32'h00FF_FFFF;
      r = int'($urandom_range(0, 9));
      write_word($urandom, int'($urandom_range(0, 3)), (r == 0) ? 1 : ((r == 1) ? 2 : 0), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge wb_clk);
    end

    // Asynchronous reset while the bus cycle is open.
    base_address = 32'h1000;
    buffer_words = 16'd4;
    start_sram   = 1'b1;
    data_in      = 32'hCAFE_F00D;
    @(negedge wb_clk);
    chk_on = 1'b0;
    check("arst_pre_cyc", {31'd0, m_wb_cyc_o}, 32'd1);
    #2 wb_rst = 1'b0;
    #1;
    check("arst_cyc", {31'd0, m_wb_cyc_o}, 32'd0);
    check("arst_stb", {31'd0, m_wb_stb_o}, 32'd0);
    check("arst_done", {31'd0, data_done}, 32'd0);
    start_sram = 1'b0;
    m_idx = 16'd0; m_count = 16'd0; m_err = 1'b0;
    e_cyc = 1'b0; e_done = 1'b0; e_wrap = 1'b0;
    repeat (2) @(negedge wb_clk);
    wb_rst = 1'b1;
    chk_on = 1'b1;
    repeat (2) @(negedge wb_clk);
    write_word(32'h6666_6666, 0, 0, 1'b0);
    check("arst_adr", cap_adr, 32'h1000);

`ifdef DAQ_SRAM_WRITER_TIMEOUT_EN
    // Slave never responds: eight WRITE cycles, then abort with error.
    write_word(32'h7777_7777, 7, 3, 1'b0);
    check("to_done", {31'd0, cap_done}, 32'd1);
    check("to_error", {31'd0, error}, 32'd1);
    write_word(32'h8888_8888, 0, 0, 1'b0);
    check("to_idx_adr", cap_adr, 32'h1004);
`endif

    repeat (2) @(negedge wb_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
